// File: rtl/fifo_lvl.sv
// fifo_lvl: first-word-fall-through FIFO with registered level count, almost-full/empty
// thresholds, sticky overflow/underflow flags and synchronous flush.
module fifo_lvl #(
  parameter int data_width = 8,
  parameter int addr_width = 7,
  parameter int af_level = 2**addr_width - 4,
  parameter int ae_level = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  clr_i,
  input  logic                  wr_i,
  input  logic                  rd_i,
  input  logic [data_width-1:0] w_data_i,
  output logic [data_width-1:0] r_data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic [addr_width:0]   count_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);
  localparam logic [addr_width:0] af_l = af_level[addr_width:0];
  localparam logic [addr_width:0] ae_l = ae_level[addr_width:0];
  logic [data_width-1:0] mem [2**addr_width];
  logic [addr_width-1:0] w_ptr_q, w_ptr_d, r_ptr_q, r_ptr_d;
  logic [addr_width:0]   count_q, count_d;
  logic                  ovf_q, ovf_d, unf_q, unf_d;
  logic                  wr_ok, rd_ok;
  // count never exceeds depth, so its top bit alone marks full
  assign full_o         = count_q[addr_width];
  assign empty_o        = count_q == '0;
  assign almost_full_o  = count_q >= af_l;
  assign almost_empty_o = count_q <= ae_l;
  assign count_o        = count_q;
  assign overflow_o     = ovf_q;
  assign underflow_o    = unf_q;
  assign r_data_o       = mem[r_ptr_q];
  always_comb begin
    wr_ok   = wr_i & (~full_o | rd_i);
    rd_ok   = rd_i & ~empty_o;
    w_ptr_d = wr_ok ? w_ptr_q + 1'b1 : w_ptr_q;
    r_ptr_d = rd_ok ? r_ptr_q + 1'b1 : r_ptr_q;
    count_d = (wr_ok == rd_ok) ? count_q : wr_ok ? count_q + 1'b1 : count_q - 1'b1;
    ovf_d   = ovf_q | (wr_i & ~wr_ok);
    unf_d   = unf_q | (rd_i & ~rd_ok);
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else if (clr_i) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end
  always_ff @(posedge clk_i)
    if (wr_ok && !clr_i) mem[w_ptr_q] <= w_data_i;
endmodule

// File: tb/tb_fifo_lvl.sv
// tb_fifo_lvl: directed scenarios for fifo_lvl at depth 4, af_level 3, ae_level 1.
module tb_fifo_lvl;
  logic       clk_i = 1'b0, reset_i = 1'b1, clr_i = 1'b0, wr_i = 1'b0, rd_i = 1'b0;
  logic [7:0] w_data_i = '0, r_data_o;
  logic       full_o, empty_o, almost_full_o, almost_empty_o, overflow_o, underflow_o;
  logic [2:0] count_o;
  int total = 0, bad = 0;

  fifo_lvl #(.data_width(8), .addr_width(2), .af_level(3), .ae_level(1)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .clr_i(clr_i), .wr_i(wr_i), .rd_i(rd_i),
    .w_data_i(w_data_i), .r_data_o(r_data_o), .full_o(full_o), .empty_o(empty_o),
    .almost_full_o(almost_full_o), .almost_empty_o(almost_empty_o), .count_o(count_o),
    .overflow_o(overflow_o), .underflow_o(underflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic drive(input logic w, input logic r, input logic [7:0] d, input logic c);
    @(negedge clk_i);
    wr_i = w; rd_i = r; w_data_i = d; clr_i = c;
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
    wr_i = 1'b0; rd_i = 1'b0; clr_i = 1'b0;
  endtask

  task automatic test_reset;
    total++;
    if ({count_o, empty_o, full_o, almost_empty_o, almost_full_o, overflow_o, underflow_o} !== {3'd0, 6'b101000}) begin
      bad++;
      $display("FAIL reset: count=%0d e=%b f=%b ae=%b af=%b ovf=%b unf=%b, want count=0 e=1 f=0 ae=1 af=0 ovf=0 unf=0",
               count_o, empty_o, full_o, almost_empty_o, almost_full_o, overflow_o, underflow_o);
    end
  endtask

  task automatic test_fill;
    logic [7:0] data [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [3:0] ae_t = 4'b0001, af_t = 4'b1100, fu_t = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, data[i], 0);
      tick();
      total++;
      if ({count_o, almost_empty_o, almost_full_o, full_o} !== {3'(i + 1), ae_t[i], af_t[i], fu_t[i]}) begin
        bad++;
        $display("FAIL fill%0d: count=%0d ae=%b af=%b f=%b, want count=%0d ae=%b af=%b f=%b",
                 i, count_o, almost_empty_o, almost_full_o, full_o, i + 1, ae_t[i], af_t[i], fu_t[i]);
      end
    end
  endtask

  task automatic test_overflow;
    logic [7:0] exp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    drive(1, 0, 8'h55, 0);
    tick();
    total++;
    if ({count_o, overflow_o, underflow_o} !== {3'd4, 2'b10}) begin
      bad++;
      $display("FAIL overflow: count=%0d ovf=%b unf=%b, want count=4 ovf=1 unf=0", count_o, overflow_o, underflow_o);
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 8'h00, 0);
      total++;
      if (r_data_o !== exp[i]) begin
        bad++;
        $display("FAIL ovf_drain%0d: r_data=%h, want %h", i, r_data_o, exp[i]);
      end
      tick();
    end
    total++;
    if ({empty_o, overflow_o, count_o} !== {2'b11, 3'd0}) begin
      bad++;
      $display("FAIL ovf_after_drain: empty=%b ovf=%b count=%0d, want empty=1 ovf=1 count=0", empty_o, overflow_o, count_o);
    end
  endtask

  task automatic test_full_rw;
    logic [7:0] exp [4] = '{8'h22, 8'h33, 8'h44, 8'h66};
    drive(0, 0, 8'h00, 1);
    tick();
    test_fill();
    drive(1, 1, 8'h66, 0);
    total++;
    if (r_data_o !== 8'h11) begin
      bad++;
      $display("FAIL full_rw_head: r_data=%h, want 11", r_data_o);
    end
    tick();
    total++;
    if ({count_o, full_o, overflow_o} !== {3'd4, 2'b10}) begin
      bad++;
      $display("FAIL full_rw: count=%0d full=%b ovf=%b, want count=4 full=1 ovf=0", count_o, full_o, overflow_o);
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 8'h00, 0);
      total++;
      if (r_data_o !== exp[i]) begin
        bad++;
        $display("FAIL full_rw_drain%0d: r_data=%h, want %h", i, r_data_o, exp[i]);
      end
      tick();
    end
  endtask

  task automatic test_empty_rw;
    drive(1, 1, 8'h77, 0);
    tick();
    total++;
    if ({count_o, r_data_o, underflow_o, overflow_o} !== {3'd1, 8'h77, 2'b10}) begin
      bad++;
      $display("FAIL empty_rw: count=%0d r_data=%h unf=%b ovf=%b, want count=1 r_data=77 unf=1 ovf=0",
               count_o, r_data_o, underflow_o, overflow_o);
    end
    drive(0, 1, 8'h00, 0);
    tick();
  endtask

  task automatic test_wrap;
    drive(0, 0, 8'h00, 1);
    tick();
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 8'(i), 0);
      tick();
      drive(0, 1, 8'h00, 0);
      total++;
      if ({count_o, r_data_o} !== {3'd1, 8'(i)}) begin
        bad++;
        $display("FAIL wrap%0d: count=%0d r_data=%h, want count=1 r_data=%h", i, count_o, r_data_o, 8'(i));
      end
      tick();
    end
    total++;
    if ({count_o, empty_o, overflow_o, underflow_o} !== {3'd0, 3'b100}) begin
      bad++;
      $display("FAIL wrap_end: count=%0d e=%b ovf=%b unf=%b, want count=0 e=1 ovf=0 unf=0",
               count_o, empty_o, overflow_o, underflow_o);
    end
  endtask

  task automatic test_flush_reset;
    drive(0, 1, 8'h00, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 8'(8'hA0 + i), 0);
      tick();
    end
    drive(0, 1, 8'h00, 0);
    tick();
    total++;
    if ({count_o, overflow_o, underflow_o} !== {3'd3, 2'b11}) begin
      bad++;
      $display("FAIL flush_setup: count=%0d ovf=%b unf=%b, want count=3 ovf=1 unf=1", count_o, overflow_o, underflow_o);
    end
    drive(1, 0, 8'h99, 1);
    tick();
    total++;
    if ({count_o, empty_o, overflow_o, underflow_o} !== {3'd0, 3'b100}) begin
      bad++;
      $display("FAIL flush: count=%0d e=%b ovf=%b unf=%b, want count=0 e=1 ovf=0 unf=0",
               count_o, empty_o, overflow_o, underflow_o);
    end
    drive(1, 0, 8'hB1, 0);
    tick();
    drive(1, 0, 8'hB2, 0);
    tick();
    total++;
    if ({count_o, r_data_o} !== {3'd2, 8'hB1}) begin
      bad++;
      $display("FAIL refill: count=%0d r_data=%h, want count=2 r_data=b1", count_o, r_data_o);
    end
    @(negedge clk_i);
    #2 reset_i = 1'b1;
    #1;
    total++;
    if ({count_o, empty_o, full_o} !== {3'd0, 2'b10}) begin
      bad++;
      $display("FAIL async_reset: count=%0d e=%b f=%b, want count=0 e=1 f=0", count_o, empty_o, full_o);
    end
    @(negedge clk_i);
    reset_i = 1'b0;
    tick();
    test_reset();
  endtask

  initial begin
    repeat (2) @(posedge clk_i);
    #1;
    test_reset();
    @(negedge clk_i);
    reset_i = 1'b0;
    test_fill();
    test_overflow();
    test_full_rw();
    test_empty_rw();
    test_wrap();
    test_flush_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fifo_lvl.md
# fifo_lvl

Parametrised successor to the UART buffer FIFO: a single-clock, first-word-fall-through FIFO with a registered fill-level count and programmable almost-full/almost-empty thresholds. It also accepts a read and a write in the same cycle while full, has sticky overflow/underflow error flags, and has a synchronous flush. It sits between the UART receiver/transmitter datapaths and the host-side register interface, replacing the plain FIFO wherever flow control needs level information.

## Interface
- data_width, 8, word width in bits
- addr_width, 7, pointer width; depth = 2^addr_width words
- af_level, 2^addr_width - 4, almost_full asserts when count >= af_level (legal range 1..depth)
- ae_level, 4, almost_empty asserts when count <= ae_level (legal range 0..depth-1)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears pointers, count and flags
- clr  input  1  synchronous flush: empties the FIFO and clears the sticky flags
- wr  input  1  write request; w_data is captured when accepted
- rd  input  1  read request; pops the head word when accepted
- w_data  input  data_width  write data
- r_data  output  data_width  head word (fall-through, combinational from storage)
- full  output  1  count == depth
- empty  output  1  count == 0
- almost_full  output  1  count >= af_level
- almost_empty  output  1  count <= ae_level
- count  output  addr_width+1  number of stored words, 0..depth
- overflow  output  1  sticky: a write was refused
- underflow  output  1  sticky: a read was refused

## Operation
- Storage: depth x data_width array, not reset. Write pointer w_ptr and read pointer r_ptr are addr_width bits and wrap naturally modulo depth. count is an explicit register.
- Write acceptance: wr_ok = wr & (~full | rd).
  - A write while full is accepted only when a read is also requested in the same cycle.
- Read acceptance: rd_ok = rd & ~empty.
  - A read while empty is never accepted, even if wr is also high.
- Accepted write: mem[w_ptr] <= w_data; w_ptr <= w_ptr + 1.
- Accepted read: r_ptr <= r_ptr + 1.
- Count update:
  - +1 on wr_ok only
  - -1 on rd_ok only
  - unchanged on both or neither
- Error flags:
  - overflow is set on wr & ~wr_ok.
  - underflow is set on rd & ~rd_ok.
  - Both hold until clr or reset.
- Empty with wr & rd in the same cycle: the write is accepted, count becomes 1, and underflow is set.
- Full with wr & rd in the same cycle: both are accepted, count stays at depth, full stays high, and no overflow is flagged.
  - When full, w_ptr == r_ptr, so the write targets the slot being read. r_data in that cycle shows the old word; the new word is stored at the edge.
- Status outputs full, empty, almost_full and almost_empty are decoded combinationally from the count register only, so they are glitch-free relative to clk.
- clr:
  - Sets w_ptr, r_ptr and count to 0 and clears overflow and underflow.
  - Has priority over wr/rd in the same cycle; neither is accepted and no error flag is set.
  - Array contents are not cleared.
- r_data = mem[r_ptr] at all times. Its value is meaningful only while empty = 0.
- States: there is no explicit FSM. The block state is (count, pointers, flags); its behaviour is fully defined by the rules above.

## Timing
- Reset values:
  - count = 0, empty = 1, full = 0
  - almost_empty = 1 (because ae_level >= 0), almost_full = 0
  - overflow = 0, underflow = 0
  - r_data is undefined
- reset asserts asynchronously mid-transfer and is released synchronously to clk by the system.
- Write-to-read latency: a word written at edge N appears on r_data and deasserts empty after edge N (zero-cycle fall-through). It can be popped with rd in cycle N+1.
- Read: r_data is valid in the same cycle rd is asserted. The next word appears after the edge.
- count and all status flags update on the same edge as the accepted operation, with no extra pipeline stage.
- Error flags rise on the edge following the refused request.
- Throughput: one write and one read per cycle, sustained, at any level.

## Test plan
Parameters for all scenarios: data_width = 8, addr_width = 2 (depth 4), af_level = 3, ae_level = 1.
- Fill and drain after reset:
  - Write 0x11, 0x22, 0x33, 0x44 on consecutive cycles. Expect count to step 1, 2, 3, 4; almost_empty drops after the 2nd write; almost_full rises after the 3rd; full rises after the 4th.
  - Then read 4 times. Expect r_data = 0x11, 0x22, 0x33, 0x44 in order, and empty = 1 at the end.
- Overflow: while full, pulse wr alone with 0x55. Expect count to stay 4, overflow = 1 and sticky, and the later drain to return 0x11..0x44 with 0x55 absent.
- Full with simultaneous wr & rd: at full, wr = 1 with 0x66 and rd = 1 in one cycle. Expect r_data = 0x11 in that cycle, count to stay 4, no overflow, and a drain to return 0x22, 0x33, 0x44, 0x66.
- Empty with simultaneous wr & rd: write 0x77 with rd = 1. Expect count = 1, r_data = 0x77, underflow = 1.
- Wrap-around: run 10 cycles of single write followed by single read with data 0x00..0x09. Expect every value returned in order, count never exceeding 1, and no error flags.
- Flush and reset:
  - With count = 3 and both error flags set, assert clr together with wr. Expect count = 0, empty = 1, flags cleared, and the write ignored.
  - Then refill 2 words and assert reset between clock edges. Expect count = 0 and empty = 1 immediately, without waiting for a clock edge.
